mac_tile_scheduler: RTL and testbench
=====================================

// Module: mac_tile_scheduler
// PURPOSE
//  Sequences one GEMM job over the multiplier_array. Walks tile indices (m,k,n) with k innermost.
//  Issues operand-fetch requests and drives array enable/in_valid.
//  Tracks the multiplier pipeline latency and emits aligned first/last tags to the downstream accumulator.
//  Sits between the job/config front-end, the operand buffers and the multiplier array.
// PARAMETERS
//  TILE_M   4  rows per tile (passed through to the array; not used in control arithmetic)
//  TILE_K   8  reduction depth per tile (pass-through)
//  TILE_N   4  cols per tile (pass-through)
//  CNT_W    8  width of the tile-count and tile-index fields
//  MUL_LAT  1  multiplier_array latency in cycles (>=1), issue -> out
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      asynchronous, active-high; clears all state
//  cfg_valid       in   1      job descriptor valid
//  cfg_ready       out  1      high only in IDLE
//  cfg_m_tiles     in   CNT_W  number of M tiles
//  cfg_k_tiles     in   CNT_W  number of K tiles
//  cfg_n_tiles     in   CNT_W  number of N tiles
//  fetch_valid     out  1      operand fetch request for the current indices
//  fetch_ready     in   1      operand buffers deliver the tile this cycle
//  fetch_m_idx     out  CNT_W  current M tile index
//  fetch_k_idx     out  CNT_W  current K tile index
//  fetch_n_idx     out  CNT_W  current N tile index
//  array_enable    out  1      multiplier_array enable
//  array_in_valid  out  2      [0]=issue (fetch handshake), [1]=first K tile of this issue
//  acc_valid       out  1      array output valid, MUL_LAT cycles after issue
//  acc_first       out  1      accumulator clears (k==0), aligned with acc_valid
//  acc_last        out  1      accumulator commits (k==K-1), aligned with acc_valid
//  busy            out  1      state != IDLE
//  done            out  1      one-cycle pulse at job completion
// BEHAVIOUR
//  - Reset values: all outputs 0 except cfg_ready=1. Counters, tag pipe and state cleared; state=IDLE.
//  - FSM states: IDLE, ISSUE, DRAIN, DONE.
//  - IDLE: cfg_ready=1. On cfg_valid, latch the three counts and zero the indices.
//    If any count==0, go to DONE; else go to ISSUE.
//  - ISSUE: fetch_valid=1.
//    - Handshake = fetch_valid & fetch_ready. array_in_valid[0] = handshake; [1] = handshake & (k==0).
//    - On handshake, advance k. On k wrap, k=0 and advance n. On n wrap, n=0 and advance m.
//    - Handshake at (M-1,K-1,N-1) goes to DRAIN.
//    - fetch_ready low means no advance and no issue (bubble); indices hold.
//  - DRAIN: hold MUL_LAT cycles (drain counter MUL_LAT-1..0), fetch_valid=0, then go to DONE.
//  - DONE: done=1 for one cycle, then IDLE.
//  - array_enable = busy. The array pipeline free-runs while busy; bubbles are marked by in_valid[0]=0.
//  - Tag pipe: MUL_LAT-deep shift register of {valid, first, last}. Shifts every cycle and is cleared in IDLE.
//    acc_* = pipe tail. acc_last is true when issued k==K-1.
//  - Latency: first fetch_valid appears the cycle after the cfg handshake.
//    acc_valid for an issue at cycle t appears at t+MUL_LAT. done follows the final acc_valid by one cycle.
//  - Counter compares use latched counts minus 1 at CNT_W bits. Counts up to 2^CNT_W-1 are legal.
//  - cfg_valid while busy is ignored (cfg_ready=0); the descriptor is not sampled.
//  - Reset mid-job: immediate return to IDLE. No done pulse, acc_valid drops. The in-flight job is lost.
// STRUCTURE
//  - Shared package mac_sched_pkg: state enum (IDLE/ISSUE/DRAIN/DONE), tag struct {valid,first,last}.
//  - Sub-module tile_idx_counter: 3-level nested counter with inc, clear, wrap flags and all_last.
//  - The scheduler keeps the FSM, drain counter and tag pipe.
// TESTING
//  1. reset held, then released -> cfg_ready=1, all other outputs 0.
//     Assert reset during ISSUE -> IDLE next edge, no done.
//  2. Job M=1,K=2,N=1, MUL_LAT=1, fetch_ready=1, cfg handshake at c0:
//     - issues at c1 (k0) and c2 (k1);
//     - acc_valid at c2 (first=1) and c3 (last=1);
//     - done at c4, cfg_ready at c5.
//  3. Job M=2,K=2,N=2 -> fetch index order (0,0,0),(0,1,0),(0,0,1),(0,1,1),(1,0,0),...,(1,1,1).
//     8 issues, 4 acc_first, 4 acc_last.
//  4. Same as 2 with fetch_ready low at c2 -> indices hold, in_valid[0]=0 at c2,
//     k1 issues at c3, acc_valid gap at c3, done at c5.
//  5. cfg_k_tiles=0 -> no fetch_valid, done one cycle after the cfg handshake.
//     cfg_valid pulsed while busy -> ignored.
//  6. MUL_LAT=3, job 1x1x1 -> issue c1, acc_valid c4 with first=last=1, done c5.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC tile scheduler: FSM state encoding and the
// {valid, first, last} tag that travels alongside the multiplier pipeline.
package mac_sched_pkg;

  // Scheduler state encoding (plain constants so legacy code can compare raw bits)
  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_ISSUE = 2'd1;
  localparam sched_state_t ST_DRAIN = 2'd2;
  localparam sched_state_t ST_DONE  = 2'd3;

  // Tag carried down the latency-matching pipe
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  localparam tag_t TAG_NONE = tag_t'(3'b000);

  // Build a tag; first/last are only meaningful together with valid
  function automatic tag_t make_tag(input logic valid, input logic first, input logic last);
    tag_t t;
    t.valid = valid;
    t.first = valid & first;
    t.last  = valid & last;
    return t;
  endfunction

endpackage

// File: rtl/tile_idx_counter.sv
// Three-level nested tile index counter (m outer, n middle, k inner).
// Limits are supplied as "count minus one"; the indices wrap back to zero
// after the last tile so a finished job leaves the counter at (0,0,0).
module tile_idx_counter
  import mac_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] m_max,
  input  logic [CNT_W-1:0] k_max,
  input  logic [CNT_W-1:0] n_max,
  output logic [CNT_W-1:0] m_idx,
  output logic [CNT_W-1:0] k_idx,
  output logic [CNT_W-1:0] n_idx,
  output logic             k_first,
  output logic             k_wrap,
  output logic             all_last
);

  localparam logic [CNT_W-1:0] IDX_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] m_idx_r;
  logic [CNT_W-1:0] k_idx_r;
  logic [CNT_W-1:0] n_idx_r;
  logic             m_last_s;
  logic             k_last_s;
  logic             n_last_s;

  assign m_last_s = (m_idx_r == m_max);
  assign k_last_s = (k_idx_r == k_max);
  assign n_last_s = (n_idx_r == n_max);

  assign m_idx    = m_idx_r;
  assign k_idx    = k_idx_r;
  assign n_idx    = n_idx_r;
  assign k_first  = (k_idx_r == IDX_ZERO);
  assign k_wrap   = inc & k_last_s;
  assign all_last = m_last_s & k_last_s & n_last_s;

  // Advance k every increment; carry into n on k wrap, into m on n wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idx_r <= IDX_ZERO;
      k_idx_r <= IDX_ZERO;
      n_idx_r <= IDX_ZERO;
    end else if (clear) begin
      m_idx_r <= IDX_ZERO;
      k_idx_r <= IDX_ZERO;
      n_idx_r <= IDX_ZERO;
    end else if (inc) begin
      if (k_last_s) begin
        k_idx_r <= IDX_ZERO;
        if (n_last_s) begin
          n_idx_r <= IDX_ZERO;
          if (m_last_s) begin
            m_idx_r <= IDX_ZERO;
          end else begin
            m_idx_r <= m_idx_r + IDX_ONE;
          end
        end else begin
          n_idx_r <= n_idx_r + IDX_ONE;
        end
      end else begin
        k_idx_r <= k_idx_r + IDX_ONE;
      end
    end else begin
      m_idx_r <= m_idx_r;
      k_idx_r <= k_idx_r;
      n_idx_r <= n_idx_r;
    end
  end

endmodule

// File: rtl/mac_tile_scheduler.sv
// Sequences one GEMM job over the multiplier array: walks (m,k,n) tiles with
// k innermost, requests operands, drives the array enables and delays the
// first/last accumulator tags by the array latency so they line up with data.
module mac_tile_scheduler
  import mac_sched_pkg::*;
#(
  parameter int TILE_M  = 4,
  parameter int TILE_K  = 8,
  parameter int TILE_N  = 4,
  parameter int CNT_W   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_m_tiles,
  input  logic [CNT_W-1:0] cfg_k_tiles,
  input  logic [CNT_W-1:0] cfg_n_tiles,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [CNT_W-1:0] fetch_m_idx,
  output logic [CNT_W-1:0] fetch_k_idx,
  output logic [CNT_W-1:0] fetch_n_idx,
  output logic             array_enable,
  output logic [1:0]       array_in_valid,
  output logic             acc_valid,
  output logic             acc_first,
  output logic             acc_last,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Drain counter runs MUL_LAT-1 down to 0
  localparam int                 DRAIN_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MUL_LAT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_ZERO = {DRAIN_W{1'b0}};
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = {{(DRAIN_W-1){1'b0}}, 1'b1};

  sched_state_t     state_r;
  sched_state_t     state_nx_s;
  logic [CNT_W-1:0] m_cnt_r;
  logic [CNT_W-1:0] k_cnt_r;
  logic [CNT_W-1:0] n_cnt_r;
  logic [CNT_W-1:0] m_max_s;
  logic [CNT_W-1:0] k_max_s;
  logic [CNT_W-1:0] n_max_s;
  logic [DRAIN_W-1:0] drain_r;
  tag_t             tag_pipe_r [MUL_LAT];
  tag_t             tag_in_s;

  logic cfg_hs_s;
  logic any_zero_s;
  logic fetch_valid_s;
  logic fetch_hs_s;
  logic k_first_s;
  logic k_wrap_s;
  logic all_last_s;

  assign cfg_hs_s      = cfg_valid & (state_r == ST_IDLE);
  assign any_zero_s    = (cfg_m_tiles == CNT_ZERO) | (cfg_k_tiles == CNT_ZERO) |
                         (cfg_n_tiles == CNT_ZERO);
  assign fetch_valid_s = (state_r == ST_ISSUE);
  assign fetch_hs_s    = fetch_valid_s & fetch_ready;

  // Limits are compared at CNT_W bits so a count of 2^CNT_W-1 still works
  assign m_max_s = m_cnt_r - CNT_ONE;
  assign k_max_s = k_cnt_r - CNT_ONE;
  assign n_max_s = n_cnt_r - CNT_ONE;

  tile_idx_counter #(
    .CNT_W(CNT_W)
  ) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clear    (cfg_hs_s),
    .inc      (fetch_hs_s),
    .m_max    (m_max_s),
    .k_max    (k_max_s),
    .n_max    (n_max_s),
    .m_idx    (fetch_m_idx),
    .k_idx    (fetch_k_idx),
    .n_idx    (fetch_n_idx),
    .k_first  (k_first_s),
    .k_wrap   (k_wrap_s),
    .all_last (all_last_s)
  );

  // Latch the job descriptor on the config handshake only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt_r <= CNT_ZERO;
      k_cnt_r <= CNT_ZERO;
      n_cnt_r <= CNT_ZERO;
    end else if (cfg_hs_s) begin
      m_cnt_r <= cfg_m_tiles;
      k_cnt_r <= cfg_k_tiles;
      n_cnt_r <= cfg_n_tiles;
    end else begin
      m_cnt_r <= m_cnt_r;
      k_cnt_r <= k_cnt_r;
      n_cnt_r <= n_cnt_r;
    end
  end

  // Next-state logic: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE (empty jobs skip to DONE)
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_hs_s) begin
          if (any_zero_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_ISSUE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (fetch_hs_s && all_last_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_ZERO) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Drain counter: preloaded while issuing, counts down while draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_r <= DRAIN_ZERO;
    end else if (state_r == ST_ISSUE) begin
      drain_r <= DRAIN_INIT;
    end else if ((state_r == ST_DRAIN) && (drain_r != DRAIN_ZERO)) begin
      drain_r <= drain_r - DRAIN_ONE;
    end else begin
      drain_r <= drain_r;
    end
  end

  // Tag entering the pipe this cycle; bubbles enter as invalid tags
  assign tag_in_s = make_tag(fetch_hs_s, k_first_s, k_wrap_s);

  // Latency-matching tag pipe: free-runs while busy, flushed in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_pipe_r[i] <= TAG_NONE;
      end
    end else if (state_r == ST_IDLE) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_pipe_r[i] <= TAG_NONE;
      end
    end else begin
      tag_pipe_r[0] <= tag_in_s;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_pipe_r[i] <= tag_pipe_r[i-1];
      end
    end
  end

  assign cfg_ready      = (state_r == ST_IDLE);
  assign busy           = (state_r != ST_IDLE);
  assign done           = (state_r == ST_DONE);
  assign fetch_valid    = fetch_valid_s;
  assign array_enable   = (state_r != ST_IDLE);
  assign array_in_valid = {fetch_hs_s & k_first_s, fetch_hs_s};
  assign acc_valid      = tag_pipe_r[MUL_LAT-1].valid;
  assign acc_first      = tag_pipe_r[MUL_LAT-1].first;
  assign acc_last       = tag_pipe_r[MUL_LAT-1].last;

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Scoreboard bench for mac_tile_scheduler: two instances (MUL_LAT=1 and 3)
// share clock, reset, counts and fetch_ready; expected issues, accumulator
// tags and done pulses are queued with their cycle numbers by the stimulus
// and popped by per-instance monitors on the falling edge.
module tb_mac_tile_scheduler;

  localparam int CNT_W = 8;

  localparam int S_ISS1  = 0;
  localparam int S_ACC1  = 1;
  localparam int S_DONE1 = 2;
  localparam int S_ISS3  = 3;
  localparam int S_ACC3  = 4;
  localparam int S_DONE3 = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_valid = 1'b0;
  logic cfg_valid3 = 1'b0;
  logic fetch_ready = 1'b1;
  logic [CNT_W-1:0] cfg_m = 8'd0;
  logic [CNT_W-1:0] cfg_k = 8'd0;
  logic [CNT_W-1:0] cfg_n = 8'd0;

  logic cfg_ready1, fetch_valid1, array_enable1, acc_valid1, acc_first1, acc_last1, busy1, done1;
  logic [CNT_W-1:0] m1, k1, n1;
  logic [1:0] inv1;
  logic cfg_ready3, fetch_valid3, array_enable3, acc_valid3, acc_first3, acc_last3, busy3, done3;
  logic [CNT_W-1:0] m3, k3, n3;
  logic [1:0] inv3;

  always #5 clk = ~clk;

  mac_tile_scheduler #(.TILE_M(4), .TILE_K(8), .TILE_N(4), .CNT_W(CNT_W), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1),
    .cfg_m_tiles(cfg_m), .cfg_k_tiles(cfg_k), .cfg_n_tiles(cfg_n),
    .fetch_valid(fetch_valid1), .fetch_ready(fetch_ready),
    .fetch_m_idx(m1), .fetch_k_idx(k1), .fetch_n_idx(n1),
    .array_enable(array_enable1), .array_in_valid(inv1),
    .acc_valid(acc_valid1), .acc_first(acc_first1), .acc_last(acc_last1),
    .busy(busy1), .done(done1)
  );

  mac_tile_scheduler #(.TILE_M(4), .TILE_K(8), .TILE_N(4), .CNT_W(CNT_W), .MUL_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_m_tiles(cfg_m), .cfg_k_tiles(cfg_k), .cfg_n_tiles(cfg_n),
    .fetch_valid(fetch_valid3), .fetch_ready(fetch_ready),
    .fetch_m_idx(m3), .fetch_k_idx(k3), .fetch_n_idx(n3),
    .array_enable(array_enable3), .array_in_valid(inv3),
    .acc_valid(acc_valid3), .acc_first(acc_first3), .acc_last(acc_last3),
    .busy(busy3), .done(done3)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q [6][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Cycle number: cycle N spans rising edge N to rising edge N+1
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input int c, input logic [63:0] d);
    exp_t e;
    e.cyc  = c;
    e.data = d;
    sb_q[s].push_back(e);
  endtask

  task automatic pop_check(input int s, input string name, input logic [63:0] act);
    exp_t e;
    checks++;
    if (sb_q[s].size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output 0x%0h at cycle %0d, nothing expected", name, act, cyc);
    end else begin
      e = sb_q[s].pop_front();
      if ((act !== e.data) || (cyc != e.cyc)) begin
        errors++;
        $display("FAIL %s: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                 name, act, cyc, e.data, e.cyc);
      end
    end
  endtask

  // Expected issue word: {in_valid[1], in_valid[0], m, k, n}
  function automatic logic [63:0] iss(input logic first, input int m, input int k, input int n);
    return {38'd0, first, 1'b1, 8'(m), 8'(k), 8'(n)};
  endfunction

  function automatic logic [63:0] tag(input logic first, input logic last);
    return {62'd0, first, last};
  endfunction

  // Monitor for the MUL_LAT=1 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_valid1 && fetch_ready) pop_check(S_ISS1, "issue1", {38'd0, inv1, m1, k1, n1});
      if (acc_valid1) pop_check(S_ACC1, "acc1", {62'd0, acc_first1, acc_last1});
      if (done1) pop_check(S_DONE1, "done1", 64'd1);
    end
  end

  // Monitor for the MUL_LAT=3 instance
  always @(negedge clk) begin
    if (!reset) begin
      if (fetch_valid3 && fetch_ready) pop_check(S_ISS3, "issue3", {38'd0, inv3, m3, k3, n3});
      if (acc_valid3) pop_check(S_ACC3, "acc3", {62'd0, acc_first3, acc_last3});
      if (done3) pop_check(S_DONE3, "done3", 64'd1);
    end
  end

  // Config handshake in the current cycle (called at rising edge + 1)
  task automatic start_job(input bit use3, input int m, input int k, input int n, output int t0);
    cfg_m = 8'(m);
    cfg_k = 8'(k);
    cfg_n = 8'(n);
    if (use3) begin
      cfg_valid3 = 1'b1;
      check("cfg_ready3_before_job", {63'd0, cfg_ready3}, 64'd1);
    end else begin
      cfg_valid = 1'b1;
      check("cfg_ready1_before_job", {63'd0, cfg_ready1}, 64'd1);
    end
    t0 = cyc;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    cfg_valid3 = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t0;
    int c;

    // 1. reset values
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_state1",
          {30'd0, cfg_ready1, fetch_valid1, array_enable1, inv1, acc_valid1, acc_first1,
           acc_last1, busy1, done1, m1, k1, n1},
          {30'd0, 1'b1, 33'd0});
    check("reset_state3",
          {30'd0, cfg_ready3, fetch_valid3, array_enable3, inv3, acc_valid3, acc_first3,
           acc_last3, busy3, done3, m3, k3, n3},
          {30'd0, 1'b1, 33'd0});

    // 2. M=1,K=2,N=1, fetch always ready
    start_job(1'b0, 1, 2, 1, t0);
    push(S_ISS1, t0 + 1, iss(1'b1, 0, 0, 0));
    push(S_ISS1, t0 + 2, iss(1'b0, 0, 1, 0));
    push(S_ACC1, t0 + 2, tag(1'b1, 1'b0));
    push(S_ACC1, t0 + 3, tag(1'b0, 1'b1));
    push(S_DONE1, t0 + 4, 64'd1);
    wait_until(t0 + 4);
    check("t2_cfg_ready_in_done", {63'd0, cfg_ready1}, 64'd0);
    wait_until(t0 + 5);
    check("t2_cfg_ready_after_done", {63'd0, cfg_ready1}, 64'd1);
    wait_until(t0 + 7);

    // 3. M=2,K=2,N=2 index order, plus an ignored descriptor while busy
    start_job(1'b0, 2, 2, 2, t0);
    c = t0 + 1;
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 2; n++) begin
        for (int k = 0; k < 2; k++) begin
          push(S_ISS1, c, iss(k == 0, m, k, n));
          push(S_ACC1, c + 1, tag(k == 0, k == 1));
          c++;
        end
      end
    end
    push(S_DONE1, t0 + 10, 64'd1);
    wait_until(t0 + 3);
    cfg_m = 8'd1;
    cfg_k = 8'd1;
    cfg_n = 8'd1;
    cfg_valid = 1'b1;
    check("t3_cfg_ready_busy", {63'd0, cfg_ready1}, 64'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    wait_until(t0 + 13);

    // 4. as 2 with a fetch_ready bubble in c2
    start_job(1'b0, 1, 2, 1, t0);
    push(S_ISS1, t0 + 1, iss(1'b1, 0, 0, 0));
    push(S_ISS1, t0 + 3, iss(1'b0, 0, 1, 0));
    push(S_ACC1, t0 + 2, tag(1'b1, 1'b0));
    push(S_ACC1, t0 + 4, tag(1'b0, 1'b1));
    push(S_DONE1, t0 + 5, 64'd1);
    wait_until(t0 + 2);
    fetch_ready = 1'b0;
    #1;
    check("t4_bubble", {36'd0, fetch_valid1, 1'b0, inv1, m1, k1, n1},
          {36'd0, 1'b1, 1'b0, 2'b00, 8'd0, 8'd1, 8'd0});
    wait_until(t0 + 3);
    fetch_ready = 1'b1;
    wait_until(t0 + 8);

    // 5. zero K count: straight to done
    start_job(1'b0, 1, 0, 1, t0);
    push(S_DONE1, t0 + 1, 64'd1);
    check("t5_no_fetch", {62'd0, fetch_valid1, busy1}, {62'd0, 1'b0, 1'b1});
    wait_until(t0 + 4);

    // 6. MUL_LAT=3 instance, 1x1x1 job
    start_job(1'b1, 1, 1, 1, t0);
    push(S_ISS3, t0 + 1, iss(1'b1, 0, 0, 0));
    push(S_ACC3, t0 + 4, tag(1'b1, 1'b1));
    push(S_DONE3, t0 + 5, 64'd1);
    wait_until(t0 + 8);

    // 1b. reset during ISSUE: back to IDLE at once, no done, acc_valid drops
    start_job(1'b0, 2, 2, 2, t0);
    push(S_ISS1, t0 + 1, iss(1'b1, 0, 0, 0));
    push(S_ISS1, t0 + 2, iss(1'b0, 0, 1, 0));
    push(S_ACC1, t0 + 2, tag(1'b1, 1'b0));
    wait_until(t0 + 3);
    reset = 1'b1;
    #1;
    check("t1b_reset_mid_job", {59'd0, cfg_ready1, busy1, fetch_valid1, acc_valid1, done1},
          {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t1b_idle_after_reset", {62'd0, cfg_ready1, busy1}, {62'd0, 1'b1, 1'b0});

    // Every expected event must have been seen
    for (int s = 0; s < 6; s++) begin
      check("scoreboard_drained", 64'(sb_q[s].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
